hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 16-bit five-stage core. It drives the enable and flush (bubble-insert) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, EX-stage redirects (taken branch or jump), instruction- and data-memory busy stalls, and the halt drain sequence. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of the `stall_cycles` and `flush_events` counters.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ifid_rs, ifid_rt  in  3  source register fields of the instruction in ID.
- ifid_useRs, ifid_useRt  in  1  ID instruction actually reads rs / rt. Both are 0 for bubbles.
- id_halt  in  1  instruction in ID is HALT.
- idex_memRead, idex_regWrite  in  1  EX-stage instruction is a load / writes a register.
- idex_writereg  in  3  destination register of the EX-stage instruction.
- ex_redirect  in  1  EX resolved a taken branch or jump; PC mux selects the target this cycle.
- imem_stall  in  1  instruction memory is not returning a valid instruction this cycle.
- dmem_stall  in  1  data memory is busy; the MEM-stage access is not complete.
- wb_halt  in  1  HALT has reached WB.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register loads on the next edge when 1, holds when 0.
- ifid_flush, idex_flush  out  1  register loads an all-zero bubble on the next edge; flush overrides en.
- halted  out  1  core halted (registered).
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 while in RUN or DRAIN.
- flush_events  out  CNT_W  saturating count of cycles with ex_redirect accepted.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Signal definition: loaduse = idex_memRead & idex_regWrite & ((ifid_useRs & idex_writereg==ifid_rs) | (ifid_useRt & idex_writereg==ifid_rt)).
- Default in RUN/DRAIN: all en=1, all flush=0.
- Controls are evaluated in priority order; the first matching rule applies:
  - 1. dmem_stall: all five en=0, flushes=0. This freezes the whole pipe, and the state is held.
  - 2. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1. If in DRAIN, go to RUN (the HALT was on the wrong path). flush_events is incremented.
  - 3. loaduse, RUN only: pc_en=0, ifid_en=0, idex_flush=1. EX/MEM and MEM/WB advance. imem_stall is ignored for this cycle.
  - 4. imem_stall: pc_en=0, ifid_flush=1. The downstream stages advance.
  - 5. DRAIN: pc_en=0, ifid_flush=1, so no new instructions enter.
- RUN to DRAIN: id_halt=1 and rules 1–3 are not active. If imem_stall is also 1, take the transition; the HALT still moves into EX.
- DRAIN to HALTED: wb_halt=1 and dmem_stall=0.
- HALTED: all en=0, all flush=0, halted=1, counters frozen. The state is sticky until reset.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: the state returns to RUN immediately (asynchronously), counters go to 0, and halted goes to 0.

## Timing
- All en/flush outputs are combinational from the current state and inputs. They take effect at the next rising edge.
- Reset values, with inputs idle (all 0): pc_en=ifid_en=idex_en=exmem_en=memwb_en=1, ifid_flush=idex_flush=0, halted=0, stall_cycles=0, flush_events=0.
- Load-use penalty: exactly one bubble. On the following cycle the load is in MEM and loaduse deasserts.
- Redirect penalty: two bubbles (IF/ID and ID/EX both flushed).
- N consecutive dmem_stall cycles freeze the pipe for exactly N cycles. stall_cycles increments by N.
- HALT latency: HALT enters ID at cycle t, DRAIN starts at t+1, wb_halt arrives at t+3, and halted=1 from t+4. dmem_stall cycles add to this 1:1.
- halted, the state and the counters are registered. All other outputs have no latency.

## Test plan
- After reset release with idle inputs, check all en=1, flushes=0, halted=0, counters=0. Then pulse rst low mid-DRAIN and check the state returns to RUN and counters go to 0.
- Load-use case: idex_memRead=1, idex_regWrite=1, idex_writereg=3, ifid_rs=3, ifid_useRs=1. Require pc_en=0, ifid_en=0, idex_flush=1 for one cycle and stall_cycles=1. Repeat with ifid_useRs=0 and require no stall.
- ex_redirect with loaduse and imem_stall both true: require pc_en=1, ifid_flush=1, idex_flush=1 and flush_events incremented by 1.
- dmem_stall held for 4 cycles with ex_redirect=1: require all en=0 and flushes=0 for all 4 cycles. flush_events must be unchanged and stall_cycles must increase by 4.
- HALT sequence: id_halt at t, wb_halt at t+3. Require pc_en=0 and ifid_flush=1 during t+1..t+3, and halted=1 with all en=0 from t+4. Variant: ex_redirect at t+1 returns the FSM to RUN and halted stays 0.
- Saturation: force 2^16+5 imem_stall cycles and require stall_cycles=0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, halt drain
// and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ifid_rs,
  input  logic [2:0]       ifid_rt,
  input  logic             ifid_useRs,
  input  logic             ifid_useRt,
  input  logic             id_halt,
  input  logic             idex_memRead,
  input  logic             idex_regWrite,
  input  logic [2:0]       idex_writereg,
  input  logic             ex_redirect,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             loaduse;
  logic             rs_hit, rt_hit;

  assign rs_hit  = ifid_useRs && (idex_writereg == ifid_rs);
  assign rt_hit  = ifid_useRt && (idex_writereg == ifid_rt);
  assign loaduse = idex_memRead && idex_regWrite && (rs_hit || rt_hit);

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    stall_d    = stall_q;
    flush_d    = flush_q;

    if (state_q == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      if (dmem_stall) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (state_q == DRAIN) state_d = RUN;
        if (flush_q != '1) flush_d = flush_q + 1'b1;
      end else if (loaduse && state_q == RUN) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else begin
        if (imem_stall || state_q == DRAIN) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
        // HALT still advances into EX even when fetch is stalled
        if (state_q == RUN && id_halt) state_d = DRAIN;
      end

      // A HALT that has committed in WB outranks a younger redirect
      if (state_q == DRAIN && wb_halt && !dmem_stall) state_d = HALTED;

      if (!pc_en && stall_q != '1) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halted       = (state_q == HALTED);
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Inputs change 1ns after a rising edge; checks run before the next edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ifid_rs, ifid_rt, idex_writereg;
  logic        ifid_useRs, ifid_useRt, id_halt;
  logic        idex_memRead, idex_regWrite;
  logic        ex_redirect, imem_stall, dmem_stall, wb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, halted;
  logic [15:0] stall_cycles, flush_events;
  logic [4:0]  en;
  logic [1:0]  fl;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_useRs(ifid_useRs), .ifid_useRt(ifid_useRt),
    .id_halt(id_halt),
    .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
    .idex_writereg(idex_writereg),
    .ex_redirect(ex_redirect), .imem_stall(imem_stall),
    .dmem_stall(dmem_stall), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  assign fl = {ifid_flush, idex_flush};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_rs = 3'd0; ifid_rt = 3'd0; idex_writereg = 3'd0;
    ifid_useRs = 1'b0; ifid_useRt = 1'b0; id_halt = 1'b0;
    idex_memRead = 1'b0; idex_regWrite = 1'b0;
    ex_redirect = 1'b0; imem_stall = 1'b0;
    dmem_stall = 1'b0; wb_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #12 rst = 1'b1;
    tick();

    // reset state
    chk("rst_en", 32'(en), 32'h1f);
    chk("rst_fl", 32'(fl), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_stall", 32'(stall_cycles), 32'h0);
    chk("rst_flush", 32'(flush_events), 32'h0);

    // load-use on rs
    idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_writereg = 3'd3;
    ifid_rs = 3'd3; ifid_useRs = 1'b1;
    #2;
    chk("lu_en", 32'(en), 32'b00111);
    chk("lu_fl", 32'(fl), 32'b01);
    tick();
    chk("lu_stall", 32'(stall_cycles), 32'd1);
    idex_memRead = 1'b0;
    #2;
    chk("lu_clear_en", 32'(en), 32'h1f);

    // same regs but rs unused: no stall
    idex_memRead = 1'b1; ifid_useRs = 1'b0;
    #2;
    chk("nolu_en", 32'(en), 32'h1f);
    chk("nolu_fl", 32'(fl), 32'h0);
    tick();
    chk("nolu_stall", 32'(stall_cycles), 32'd1);

    // load-use through rt
    ifid_rt = 3'd3; ifid_useRt = 1'b1;
    #2;
    chk("lu_rt_en", 32'(en), 32'b00111);
    tick();
    chk("lu_rt_stall", 32'(stall_cycles), 32'd2);

    // redirect beats loaduse and imem_stall
    ifid_useRs = 1'b1; imem_stall = 1'b1; ex_redirect = 1'b1;
    #2;
    chk("redir_en", 32'(en), 32'h1f);
    chk("redir_fl", 32'(fl), 32'b11);
    tick();
    chk("redir_cnt", 32'(flush_events), 32'd1);
    chk("redir_stall", 32'(stall_cycles), 32'd2);

    // dmem_stall for 4 cycles with redirect pending
    idle();
    dmem_stall = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("dm_en%0d", i), 32'(en), 32'h0);
      chk($sformatf("dm_fl%0d", i), 32'(fl), 32'h0);
      tick();
    end
    chk("dm_flush", 32'(flush_events), 32'd1);
    chk("dm_stall", 32'(stall_cycles), 32'd6);

    // HALT sequence: id_halt at t
    idle();
    id_halt = 1'b1;
    #2;
    chk("h_t_en", 32'(en), 32'h1f);
    tick();
    id_halt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) wb_halt = 1'b1;
      #2;
      chk($sformatf("h_pc%0d", i), 32'(pc_en), 32'h0);
      chk($sformatf("h_fl%0d", i), 32'(fl), 32'b10);
      chk($sformatf("h_hl%0d", i), 32'(halted), 32'h0);
      tick();
    end
    wb_halt = 1'b0;
    chk("h_halted", 32'(halted), 32'h1);
    chk("h_en", 32'(en), 32'h0);
    chk("h_fl", 32'(fl), 32'h0);
    chk("h_stall", 32'(stall_cycles), 32'd9);
    imem_stall = 1'b1; ex_redirect = 1'b1;
    tick();
    chk("h_frz_stall", 32'(stall_cycles), 32'd9);
    chk("h_frz_flush", 32'(flush_events), 32'd1);
    chk("h_sticky", 32'(halted), 32'h1);

    // async reset out of HALTED
    idle();
    rst = 1'b0;
    #1;
    chk("ar_halted", 32'(halted), 32'h0);
    chk("ar_stall", 32'(stall_cycles), 32'h0);
    chk("ar_flush", 32'(flush_events), 32'h0);
    rst = 1'b1;
    tick();

    // redirect during DRAIN returns to RUN
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0; ex_redirect = 1'b1;
    #2;
    chk("dr_redir_en", 32'(en), 32'h1f);
    chk("dr_redir_fl", 32'(fl), 32'b11);
    tick();
    ex_redirect = 1'b0;
    #2;
    chk("dr_run_en", 32'(en), 32'h1f);
    chk("dr_run_fl", 32'(fl), 32'h0);
    tick();
    wb_halt = 1'b1;
    tick();
    wb_halt = 1'b0;
    tick();
    chk("dr_not_halted", 32'(halted), 32'h0);
    chk("dr_flush", 32'(flush_events), 32'd1);
    chk("dr_stall", 32'(stall_cycles), 32'd0);

    // HALT with imem_stall still enters DRAIN; loaduse ignored in DRAIN
    id_halt = 1'b1; imem_stall = 1'b1;
    #2;
    chk("hi_en", 32'(en), 32'b01111);
    chk("hi_fl", 32'(fl), 32'b10);
    tick();
    idle();
    idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_writereg = 3'd5;
    ifid_rs = 3'd5; ifid_useRs = 1'b1;
    #2;
    chk("dlu_en", 32'(en), 32'b01111);
    chk("dlu_fl", 32'(fl), 32'b10);

    // reset pulse mid-DRAIN
    tick();
    chk("pre_rst_stall", 32'(stall_cycles), 32'd2);
    idle();
    rst = 1'b0;
    #1;
    chk("md_stall", 32'(stall_cycles), 32'h0);
    chk("md_en", 32'(en), 32'h1f);
    chk("md_fl", 32'(fl), 32'h0);
    rst = 1'b1;
    tick();

    // saturation
    imem_stall = 1'b1;
    repeat (65541) @(posedge clk);
    #1;
    chk("sat_stall", 32'(stall_cycles), 32'hffff);
    tick();
    chk("sat_hold", 32'(stall_cycles), 32'hffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
